// File: rtl/pulse_stretcher_fsm.sv
// rtl/pulse_stretcher_fsm.sv - stretches trigger pulses into a registered level followed by a low guard gap
// Optional macro PULSE_STRETCH_RETRIGGER_EN: a trigger during ACTIVE reloads the level length.
module pulse_stretcher_fsm #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    input  logic [WIDTH-1:0] len,
    output logic             level_out,
    output logic             busy,
    output logic             done,
    output logic             missed,
    output logic [WIDTH-1:0] remaining
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_GUARD  = 2'd2;

    localparam bit         HAS_GUARD = (GAP > 0);
    localparam logic [7:0] GAP_LOAD  = HAS_GUARD ? 8'(GAP - 1) : 8'd0;

    logic [1:0]       state_q, state_d;
    logic             level_q, level_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             missed_q, missed_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [7:0]       gap_q, gap_d;
    logic             trig;

    // A zero-length trigger is a no-op everywhere and never counts as dropped.
    assign trig = pulse_in && (len != '0);

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        rem_d    = rem_q;
        gap_d    = gap_q;
        done_d   = 1'b0;
        missed_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                level_d = 1'b0;
                rem_d   = '0;
                if (trig) begin
                    state_d = S_ACTIVE;
                    level_d = 1'b1;
                    rem_d   = len - WIDTH'(1);
                end
            end

            S_ACTIVE: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
                // Reload beats expiry, so a trigger on the last high cycle extends the level.
                if (trig) begin
                    level_d = 1'b1;
                    rem_d   = len - WIDTH'(1);
                end else if (rem_q != '0) begin
                    rem_d = rem_q - WIDTH'(1);
                end else begin
                    level_d = 1'b0;
                    done_d  = 1'b1;
                    if (HAS_GUARD) begin
                        state_d = S_GUARD;
                        gap_d   = GAP_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
`else
                missed_d = trig;
                if (rem_q != '0) begin
                    rem_d = rem_q - WIDTH'(1);
                end else begin
                    level_d = 1'b0;
                    done_d  = 1'b1;
                    if (HAS_GUARD) begin
                        state_d = S_GUARD;
                        gap_d   = GAP_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
`endif
            end

            S_GUARD: begin
                level_d  = 1'b0;
                rem_d    = '0;
                missed_d = trig;
                if (gap_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                level_d = 1'b0;
                rem_d   = '0;
                gap_d   = 8'd0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            level_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            missed_q <= 1'b0;
            rem_q    <= '0;
            gap_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            missed_q <= missed_d;
            rem_q    <= rem_d;
            gap_q    <= gap_d;
        end
    end

    assign level_out = level_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign missed    = missed_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_pulse_stretcher_fsm.sv
// tb/tb_pulse_stretcher_fsm.sv - self-checking bench for pulse_stretcher_fsm against a timeline model
module tb_pulse_stretcher_fsm;

    localparam int WIDTH = 8;
    localparam int GAP   = 1;
`ifdef PULSE_STRETCH_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             pulse_in;
    logic [WIDTH-1:0] len;
    logic             level_out;
    logic             busy;
    logic             done;
    logic             missed;
    logic [WIDTH-1:0] remaining;

    pulse_stretcher_fsm #(.WIDTH(WIDTH), .GAP(GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .pulse_in  (pulse_in),
        .len       (len),
        .level_out (level_out),
        .busy      (busy),
        .done      (done),
        .missed    (missed),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: the most recent accepted trigger (edge a, length L) fixes the whole timeline.
    bit have = 1'b0;
    int a    = 0;
    int L    = 0;
    logic [WIDTH+3:0] exp_v;
    logic [WIDTH+3:0] obs;
    assign obs = {level_out, busy, done, missed, remaining};

    task automatic step(input bit p, input int l, input bit r);
        bit idle_b, act_b, acc, e_missed, e_level, e_busy, e_done;
        int e_rem;
        pulse_in = p;
        len      = WIDTH'(l);
        reset    = r;
        @(posedge clk);
        cyc++;
        e_missed = 1'b0;
        if (r) begin
            have = 1'b0;
        end else begin
            idle_b   = !have || (cyc - 1 > a + L - 1 + GAP);
            act_b    = have && (cyc - 1 <= a + L - 1);
            acc      = p && (l != 0) && (idle_b || (RETRIG && act_b));
            e_missed = p && (l != 0) && !acc;
            if (acc) begin
                have = 1'b1;
                a    = cyc;
                L    = l;
            end
        end
        e_level = have && (cyc >= a) && (cyc <= a + L - 1);
        e_rem   = e_level ? (a + L - 1 - cyc) : 0;
        e_done  = have && (cyc == a + L);
        e_busy  = have && (cyc <= a + L - 1 + GAP);
        exp_v   = {e_level, e_busy, e_done, e_missed, WIDTH'(e_rem)};
        @(negedge clk);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5, 1'b1);
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, obs, 12'h000);
            end
        end
        step(1'b0, 0, 1'b0);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs, 12'h000);
        end
    endtask

    task automatic test_basic;
        int rem_tab[4] = '{3, 2, 1, 0};
        step(1'b1, 4, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step(1'b0, 0, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL basic_len4 cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
            if (i < 4) begin
                checks++;
                if (remaining !== WIDTH'(rem_tab[i]) || level_out !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_remaining i=%0d got=%0d exp=%0d", i, remaining, rem_tab[i]);
                end
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_drop got=%b exp=0", busy);
        end
    endtask

    task automatic test_zero_and_one;
        step(1'b1, 0, 1'b0);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL len_zero cyc=%0d got=%h exp=%h", cyc, obs, 12'h000);
        end
        for (int i = 0; i < 4; i++) begin
            step(i == 0, 1, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL len_one cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
        end
    endtask

    task automatic test_second_trigger;
        int high_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(i == 0 || i == 2, (i == 2) ? 9 : 5, 1'b0);
            if (level_out === 1'b1) high_cnt++;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL second_trig cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
            if (i == 2) begin
                checks++;
                if (missed !== !RETRIG) begin
                    errors++;
                    $display("FAIL second_trig_missed got=%b exp=%b", missed, !RETRIG);
                end
            end
        end
        checks++;
        if (high_cnt != (RETRIG ? 11 : 5)) begin
            errors++;
            $display("FAIL second_trig_len got=%0d exp=%0d", high_cnt, RETRIG ? 11 : 5);
        end
    endtask

    task automatic test_back_to_back;
        // Pulse on every cycle of a len=3 level, including its last high cycle and the guard.
        for (int i = 0; i < 8; i++) begin
            step(i < 5, 3, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
        end
        for (int i = 0; i < 16; i++) step(1'b0, 0, 1'b0);
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) begin
            step(i == 0, 6, i == 3);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_mid cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_nodone busy=%b done=%b exp=0", busy, done);
        end
    endtask

    task automatic test_guard_drop;
        bit saw_missed = 1'b0;
        // len=2: high 2 cycles, done, then guard cycle where the pulse lands, then a fresh trigger.
        for (int i = 0; i < 8; i++) begin
            step(i == 0 || i == 3 || i == 4, 2, 1'b0);
            if (i == 3 && missed === 1'b1) saw_missed = 1'b1;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL guard_drop cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
        end
        checks++;
        if (!saw_missed) begin
            errors++;
            $display("FAIL guard_missed got=0 exp=1");
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom_range(0, 79) == 0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        pulse_in = 1'b0;
        len      = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_zero_and_one();
        test_second_trigger();
        test_back_to_back();
        test_reset_mid();
        test_guard_drop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
